// File: rtl/vga_pkg.sv
// Shared constants, colour/state types and the fixed palette for the VGA scanout path.
package vga_pkg;

   localparam logic [9:0] H_ACTIVE = 10'd640;
   localparam logic [8:0] V_ACTIVE = 9'd480;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   typedef enum logic [1:0] {IDLE, PEND, ACK} swap_state_t;

   // BattleZone monochrome ramp: green intensity equals the pixel index.
   localparam rgb_t PALETTE [16] = '{
      12'h000, 12'h010, 12'h020, 12'h030, 12'h040, 12'h050, 12'h060, 12'h070,
      12'h080, 12'h090, 12'h0A0, 12'h0B0, 12'h0C0, 12'h0D0, 12'h0E0, 12'h0F0
   };

endpackage

// File: rtl/swap_ctrl.sv
// Double-buffer select: grants a writer's swap request only at the start of vertical sync.
module swap_ctrl
   import vga_pkg::*;
(
   input  logic clk,
   input  logic rst_l,
   input  logic pix_ce,
   input  logic vsync_in,
   input  logic swap_req,
   output logic swap_ack,
   output logic disp_buf
);

   swap_state_t state_q, state_d;
   logic        vs_prev_q;
   logic        disp_q, disp_d;
   logic        vs_fall;

   // Previous sample resets low so a reset inside the sync pulse cannot fake an edge.
   assign vs_fall  = pix_ce & ~vsync_in & vs_prev_q;
   assign disp_buf = disp_q;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q   <= IDLE;
         vs_prev_q <= 1'b0;
         disp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         disp_q  <= disp_d;
         if (pix_ce) vs_prev_q <= vsync_in;
      end
   end

   always_comb begin
      state_d  = state_q;
      disp_d   = disp_q;
      swap_ack = 1'b0;
      case (state_q)
         IDLE: if (swap_req) state_d = PEND;
         PEND: begin
            if (!swap_req) state_d = IDLE;
            else if (vs_fall) begin
               disp_d  = ~disp_q;
               state_d = ACK;
            end
         end
         ACK: begin
            swap_ack = 1'b1;
            if (!swap_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/vga_scanout.sv
// Pixel scanout: (row, col) -> framebuffer read, palette lookup to registered RGB,
// pixel-aligned sync delay, and the double-buffer select owned by swap_ctrl.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int RD_LAT = 2,
   parameter int PIX_W  = 4
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             pix_ce,
   input  logic [8:0]       row_in,
   input  logic [9:0]       col_in,
   input  logic             active_in,
   input  logic             hsync_in,
   input  logic             vsync_in,
   output logic [18:0]      fb_addr,
   output logic             fb_sel,
   output logic             fb_rd_en,
   input  logic [PIX_W-1:0] fb_rdata,
   input  logic             swap_req,
   output logic             swap_ack,
   output logic             disp_buf,
   output logic [3:0]       vgaRed,
   output logic [3:0]       vgaGreen,
   output logic [3:0]       vgaBlue,
   output logic             Hsync,
   output logic             Vsync
);

   logic [18:0]      addr_q, addr_d;
   logic             sel_q;
   logic             vld_a_q, vld_d;
   logic             rd_en_q;
   logic [RD_LAT-1:0] rd_dly_q;
   logic             rd_cap;
   logic [PIX_W-1:0] pix_q, pix_nx;
   rgb_t             rgb_q, rgb_d;
   logic [1:0]       hs_q, vs_q;

   swap_ctrl u_swap (
      .clk      (clk),
      .rst_l    (rst_l),
      .pix_ce   (pix_ce),
      .vsync_in (vsync_in),
      .swap_req (swap_req),
      .swap_ack (swap_ack),
      .disp_buf (disp_buf)
   );

   // row*640 + col as shifts; the largest legal input stays well inside 19 bits.
   assign addr_d = ({10'd0, row_in} << 9) + ({10'd0, row_in} << 7) + {9'd0, col_in};
   assign vld_d  = active_in & (row_in < V_ACTIVE) & (col_in < H_ACTIVE);
   assign rd_cap = rd_dly_q[RD_LAT-1];

   // When the minimum pix_ce spacing lands the capture on the stage-B edge, use the live data.
   assign pix_nx = rd_cap ? fb_rdata : pix_q;

   always_comb begin
      rgb_d = '0;
      if (vld_a_q) rgb_d = PALETTE[pix_nx];
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         addr_q   <= '0;
         sel_q    <= 1'b0;
         vld_a_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         rd_dly_q <= '0;
         pix_q    <= '0;
         rgb_q    <= '0;
         hs_q     <= 2'b11;
         vs_q     <= 2'b11;
      end else begin
         rd_en_q  <= pix_ce & vld_d;
         rd_dly_q <= RD_LAT'({rd_dly_q, rd_en_q});
         if (rd_cap) pix_q <= fb_rdata;
         if (pix_ce) begin
            addr_q  <= addr_d;
            sel_q   <= disp_buf;
            vld_a_q <= vld_d;
            rgb_q   <= rgb_d;
            hs_q    <= {hs_q[0], hsync_in};
            vs_q    <= {vs_q[0], vsync_in};
         end
      end
   end

   assign fb_addr  = addr_q;
   assign fb_sel   = sel_q;
   assign fb_rd_en = rd_en_q;
   assign vgaRed   = rgb_q.r;
   assign vgaGreen = rgb_q.g;
   assign vgaBlue  = rgb_q.b;
   assign Hsync    = hs_q[1];
   assign Vsync    = vs_q[1];

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Pixel-side consumer of the VGA timing generator's row/col/sync outputs.
- Converts each (row, col) into a framebuffer read address and captures the returned 4-bit pixel index.
- Maps the index through a fixed palette to registered 4/4/4 RGB, with Hsync/Vsync delayed to stay pixel-aligned.
- Owns the double-buffer select: the vector-drawing writer requests a buffer swap, and the swap is granted only at vertical sync.

Parameters:
- H_ACTIVE, 640, visible columns; address stride per row.
- V_ACTIVE, 480, visible rows.
- RD_LAT, 2, clk cycles from fb_rd_en to valid fb_rdata; legal range 1..3.
- PIX_W, 4, framebuffer pixel-index width.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_l  in  1  asynchronous active-low reset
- pix_ce  in  1  one-clk pulse per pixel (every 4th clk); all pixel pipeline stages advance only on pix_ce
- row_in  in  9  visible row from timing generator
- col_in  in  10  visible column from timing generator
- active_in  in  1  high while (row_in, col_in) is in the visible area
- hsync_in  in  1  raw Hsync, active low
- vsync_in  in  1  raw Vsync, active low
- fb_addr  out  19  framebuffer word address within one buffer
- fb_sel  out  1  buffer select accompanying fb_addr
- fb_rd_en  out  1  one-clk read strobe
- fb_rdata  in  PIX_W  pixel index, valid RD_LAT clks after fb_rd_en
- swap_req  in  1  level request from writer to flip buffers
- swap_ack  out  1  4-phase acknowledge
- disp_buf  out  1  buffer currently displayed
- vgaRed, vgaGreen, vgaBlue  out  4 each  registered colour
- Hsync, Vsync  out  1 each  delayed syncs

Behaviour:
- Reset values (asynchronous, rst_l low):
  - all outputs 0, except Hsync=1 and Vsync=1 (idle high);
  - pipeline valid bits cleared; swap FSM in IDLE; disp_buf=0.
- Stage A, on pix_ce:
  - fb_addr <= row_in*640 + col_in, computed as (row_in<<9)+(row_in<<7)+col_in in 19 bits; max value 307199, never wraps.
  - fb_sel <= disp_buf.
  - vld_a <= active_in & (row_in < V_ACTIVE) & (col_in < H_ACTIVE); out-of-range coordinates are treated as blank.
  - fb_rd_en pulses for exactly that clk when vld_a is set.
- Capture: exactly RD_LAT clks after fb_rd_en, pix_q <= fb_rdata. A clk-side counter/shift tracks the read; it is not tied to pix_ce.
- Stage B, on the next pix_ce:
  - if vld_b: {vgaRed,vgaGreen,vgaBlue} <= PALETTE[pix_q];
  - otherwise the RGB outputs are 0.
- Latency: outputs reflect the (row, col) presented two pix_ce pulses earlier.
- Sync alignment: hsync_in/vsync_in pass through a 2-stage shift register advanced on pix_ce, so Hsync/Vsync keep the same alignment with RGB that they have at the inputs.
- pix_ce spacing constraint: spacing must be ≥ RD_LAT+1 clks. Behaviour under closer spacing is undefined; the bench checks the constraint with an assertion.
- Swap FSM (advances on clk; vsync edge is sampled on pix_ce):
  - IDLE: swap_ack=0. swap_req=1 → PEND.
  - PEND: on a pix_ce where vsync_in is 0 and the previously sampled vsync_in was 1 (start of sync pulse) → toggle disp_buf, go ACK.
  - ACK: swap_ack=1. When swap_req=0 → IDLE.
  - swap_req dropping while in PEND → back to IDLE with no toggle.
  - A request arriving during the vsync pulse waits for the next frame's falling edge.
  - At most one toggle per frame.
  - disp_buf changes only during vertical sync. fb_sel is sampled at stage A, so no frame ever mixes buffers.
- Reset mid-frame: pipeline is flushed and RGB goes to 0 immediately. Any pending swap is discarded, and the writer must re-request.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE/V_ACTIVE constants;
  - typedef rgb_t (struct of three 4-bit fields);
  - typedef swap_state_t enum {IDLE, PEND, ACK};
  - PALETTE: 16-entry rgb_t constant array, index 0 = black, 15 = full green 0/F/0 (BattleZone monochrome ramp).
- One sub-module, swap_ctrl, owns the FSM, vsync edge detect and disp_buf.

Test Plan:
- Reset release, pix_ce every 4 clks, row_in=1, col_in=0, active_in=1 → fb_addr=640, fb_sel=0, fb_rd_en pulses once; with fb_rdata=15, RGB=0/F/0 on the 2nd pix_ce.
- row_in=479, col_in=639 → fb_addr=307199. Same coordinates with active_in=0 → no fb_rd_en, RGB=0.
- Sync delay: toggle hsync_in low for 96 pix_ce → Hsync low for exactly 96 pix_ce, starting 2 pix_ce later.
- Swap: assert swap_req mid-frame → disp_buf toggles 0→1 only on the vsync_in falling-edge pix_ce; swap_ack holds 1 until swap_req drops, then returns to 0; the next frame's fb_sel=1.
- Swap_req pulsed and released before vsync → no toggle; disp_buf stays 0, swap_ack never asserts.
- Assert rst_l low with a swap in PEND and a read in flight → all outputs at reset values within the reset cycle; after release, disp_buf=0 and no stale RGB appears.
